// File: rtl/bc_pkg.sv
// Shared constants, level types and the saturating step helper for the brightness/contrast stage.
package bc_pkg;
  localparam int DW_DEF      = 8;
  localparam int B_STEP_DEF  = 16;
  localparam int B_MAX_DEF   = 128;
  localparam int G_UNITY_DEF = 16;
  localparam int G_STEP_DEF  = 2;
  localparam int G_MIN_DEF   = 4;
  localparam int G_MAX_DEF   = 48;
  localparam int PIPE_LAT    = 3;

  localparam int OFF_W  = 9;
  localparam int GAIN_W = 6;
  localparam int FRAC_W = 4;  // gain is Q2.4

  typedef logic signed [OFF_W-1:0] offset_t;
  typedef logic        [GAIN_W-1:0] gain_t;

  // Step a level up or down by one increment, clamped to [lo, hi]; both or neither holds.
  function automatic int sat_step(int cur, logic up, logic dn, int step, int lo, int hi);
    int v;
    v = cur;
    if (up && !dn)      v = (cur + step > hi) ? hi : cur + step;
    else if (dn && !up) v = (cur - step < lo) ? lo : cur - step;
    return v;
  endfunction
endpackage

// File: rtl/bc_channel.sv
// One colour channel of the brightness/contrast pipeline: centre, scale, offset, clamp (3 stages).
module bc_channel
  import bc_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bypass,
  input  offset_t       offset,
  input  gain_t         gain,
  input  logic [DW-1:0] pix_in,
  output logic [DW-1:0] pix_out
);
  localparam int D_W     = DW + 1;
  localparam int P_W     = D_W + GAIN_W;
  localparam int S_W     = DW + 4;
  localparam int MID     = 2 ** (DW - 1);
  localparam int PIX_MAX = 2 ** DW - 1;

  logic signed [D_W-1:0] d_c, d1;
  logic signed [P_W-1:0] p_c, q_c;
  logic signed [S_W-1:0] s_c, s2;
  logic        [DW-1:0]  raw1, raw2, clamp_c;
  logic                  byp1, byp2;
  offset_t               off1;
  gain_t                 gain1;

  always_comb begin
    d_c = D_W'($signed({1'b0, pix_in}) - MID);
    p_c = P_W'(d1) * P_W'($signed({1'b0, gain1}));
    q_c = p_c >>> FRAC_W;  // arithmetic shift floors toward -inf
    s_c = S_W'(q_c) + S_W'(MID) + S_W'(off1);
    if (s2[S_W-1])                   clamp_c = '0;
    else if (s2 > S_W'(PIX_MAX))     clamp_c = DW'(PIX_MAX);
    else                             clamp_c = s2[DW-1:0];
  end

  // NOTE: datapath registers are reset too, so a mid-frame reset drives clean zeros out at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1      <= '0;
      raw1    <= '0;
      byp1    <= 1'b0;
      off1    <= '0;
      gain1   <= '0;
      s2      <= '0;
      raw2    <= '0;
      byp2    <= 1'b0;
      pix_out <= '0;
    end else begin
      d1      <= d_c;
      raw1    <= pix_in;
      byp1    <= bypass;
      off1    <= offset;
      gain1   <= gain;
      s2      <= s_c;
      raw2    <= raw1;
      byp2    <= byp1;
      pix_out <= byp2 ? raw2 : clamp_c;
    end
  end
endmodule

// File: rtl/bc_pixel_adjust.sv
// Brightness/contrast level registers plus the 3-stage RGB adjust pipeline.
// Define BC_FRAME_SYNC_EN to defer level changes to the next frame start (in_valid & in_vsync).
module bc_pixel_adjust
  import bc_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int B_STEP  = B_STEP_DEF,
  parameter int B_MAX   = B_MAX_DEF,
  parameter int G_UNITY = G_UNITY_DEF,
  parameter int G_STEP  = G_STEP_DEF,
  parameter int G_MIN   = G_MIN_DEF,
  parameter int G_MAX   = G_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_b,
  input  logic          binc,
  input  logic          bdec,
  input  logic          cinc,
  input  logic          cdec,
  input  logic          in_valid,
  input  logic          in_vsync,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_g,
  input  logic [DW-1:0] in_b,
  output logic          out_valid,
  output logic          out_vsync,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_g,
  output logic [DW-1:0] out_b,
  output offset_t       b_level,
  output gain_t         c_level
);
  offset_t b_act, b_base, b_nxt, b_use;
  gain_t   c_act, c_base, c_nxt, c_use;
  logic    bypass;
  logic [PIPE_LAT-1:0] vld_sr, vs_sr;

  assign bypass = ~en_b;

  always_comb begin
    b_nxt = offset_t'(sat_step(int'(b_base), en_b & binc, en_b & bdec, B_STEP, -B_MAX, B_MAX));
    c_nxt = gain_t'(sat_step(int'(c_base), en_b & cinc, en_b & cdec, G_STEP, G_MIN, G_MAX));
  end

`ifdef BC_FRAME_SYNC_EN
  offset_t b_pend;
  gain_t   c_pend;
  logic    frame_load;

  assign frame_load = in_valid & in_vsync;
  assign b_base     = b_pend;
  assign c_base     = c_pend;
  // The frame-start pixel already uses the levels it loads.
  assign b_use      = frame_load ? b_pend : b_act;
  assign c_use      = frame_load ? c_pend : c_act;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_pend <= '0;
      c_pend <= gain_t'(G_UNITY);
      b_act  <= '0;
      c_act  <= gain_t'(G_UNITY);
    end else begin
      b_pend <= b_nxt;
      c_pend <= c_nxt;
      if (frame_load) begin
        b_act <= b_pend;
        c_act <= c_pend;
      end
    end
  end
`else
  assign b_base = b_act;
  assign c_base = c_act;
  assign b_use  = b_act;
  assign c_use  = c_act;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_act <= '0;
      c_act <= gain_t'(G_UNITY);
    end else begin
      b_act <= b_nxt;
      c_act <= c_nxt;
    end
  end
`endif

  assign b_level = b_act;
  assign c_level = c_act;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr <= '0;
      vs_sr  <= '0;
    end else begin
      vld_sr <= {vld_sr[PIPE_LAT-2:0], in_valid};
      vs_sr  <= {vs_sr[PIPE_LAT-2:0], in_vsync};
    end
  end

  assign out_valid = vld_sr[PIPE_LAT-1];
  assign out_vsync = vs_sr[PIPE_LAT-1];

  bc_channel #(.DW(DW)) u_ch_r (
    .clk(clk), .rst(rst), .bypass(bypass), .offset(b_use), .gain(c_use),
    .pix_in(in_r), .pix_out(out_r)
  );
  bc_channel #(.DW(DW)) u_ch_g (
    .clk(clk), .rst(rst), .bypass(bypass), .offset(b_use), .gain(c_use),
    .pix_in(in_g), .pix_out(out_g)
  );
  bc_channel #(.DW(DW)) u_ch_b (
    .clk(clk), .rst(rst), .bypass(bypass), .offset(b_use), .gain(c_use),
    .pix_in(in_b), .pix_out(out_b)
  );
endmodule

// File: tb/tb_bc_pixel_adjust.sv
// Self-checking bench for bc_pixel_adjust: directed vector table, random run against a model, reset cases.
module tb_bc_pixel_adjust;
  import bc_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en_b, binc, bdec, cinc, cdec, in_valid, in_vsync;
  logic [7:0] in_r, in_g, in_b, out_r, out_g, out_b;
  logic       out_valid, out_vsync;
  offset_t    b_level;
  gain_t      c_level;

  int total = 0;
  int bad   = 0;

  bc_pixel_adjust dut (
    .clk(clk), .rst(rst), .en_b(en_b), .binc(binc), .bdec(bdec), .cinc(cinc), .cdec(cdec),
    .in_valid(in_valid), .in_vsync(in_vsync), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_vsync(out_vsync), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .b_level(b_level), .c_level(c_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en, binc, bdec, cinc, cdec;
    int rep;
    int exp_b, exp_c;
    int r, g, b;
    int er, eg, eb;
  } vec_t;

  typedef struct {
    bit v, vs;
    int r, g, b;
  } exp_t;

  vec_t vecs[10];
  exp_t q[$];

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference pixel: centre on 128, scale by gain/16 rounding toward -inf, add offset, clamp.
  function automatic int pix_model(int x, int off, int g, bit en);
    int d, p, qq, s;
    if (!en) return x;
    d  = x - 128;
    p  = d * g;
    qq = (p >= 0) ? p / 16 : -((-p + 15) / 16);
    s  = qq + 128 + off;
    if (s < 0)   return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  function automatic int sat(int v, bit up, bit dn, int st, int lo, int hi);
    if (up && !dn) return (v + st > hi) ? hi : v + st;
    if (dn && !up) return (v - st < lo) ? lo : v - st;
    return v;
  endfunction

  task automatic idle();
    binc = 0; bdec = 0; cinc = 0; cdec = 0;
    in_valid = 0; in_vsync = 0;
  endtask

  // One frame-start pixel; out_valid must be low for two cycles and present on the third.
  task automatic send_pixel(vec_t v, string tag);
    en_b = v.en; in_valid = 1; in_vsync = 1;
    in_r = 8'(v.r); in_g = 8'(v.g); in_b = 8'(v.b);
    tick();
    idle();
    check({tag, "_lat1_valid"}, int'(out_valid), 0);
    tick();
    check({tag, "_lat2_valid"}, int'(out_valid), 0);
    tick();
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_vsync"}, int'(out_vsync), 1);
    check({tag, "_r"}, int'(out_r), v.er);
    check({tag, "_g"}, int'(out_g), v.eg);
    check({tag, "_b"}, int'(out_b), v.eb);
    check({tag, "_b_level"}, int'(b_level), v.exp_b);
    check({tag, "_c_level"}, int'(c_level), v.exp_c);
  endtask

  initial begin
    int mb, mc, pb, pc, ub, uc;
    exp_t e;
    vec_t uv;

    //          en b+ b- c+ c- rep  b_lv c_lv  r    g    b     er   eg   eb
    vecs[0] = '{1, 0, 0, 0, 0,  0,    0, 16, 200, 100,   0,  200, 100,   0};
    vecs[1] = '{1, 1, 0, 0, 0,  2,   32, 16, 250,  10, 128,  255,  42, 160};
    vecs[2] = '{1, 0, 1, 0, 0,  2,    0, 16,   0, 255, 128,    0, 255, 128};
    vecs[3] = '{1, 0, 0, 1, 0,  8,    0, 32, 200, 100, 128,  255,  72, 128};
    vecs[4] = '{1, 0, 0, 0, 1, 30,    0,  4,   0, 255,  64,   96, 159, 112};
    vecs[5] = '{1, 1, 1, 1, 1,  3,    0,  4,   0,   0,   0,   96,  96,  96};
    vecs[6] = '{0, 1, 0, 1, 0,  4,    0,  4,  77, 200,   3,   77, 200,   3};
    vecs[7] = '{1, 0, 1, 0, 0, 10, -128,  4, 255, 128,   0,   31,   0,   0};
    vecs[8] = '{1, 1, 0, 1, 0, 30,  128, 48, 128, 129, 100,  255, 255, 172};
    vecs[9] = '{1, 0, 1, 0, 0,  8,    0, 48, 100, 127, 131,   44, 125, 137};
    uv      = '{1, 0, 0, 0, 0,  0,    0, 16, 200, 100,   0,  200, 100,   0};

    rst = 0; en_b = 0; in_r = 0; in_g = 0; in_b = 0;
    idle();
    tick(); tick();
    check("reset_valid", int'(out_valid), 0);
    check("reset_out_r", int'(out_r), 0);
    check("reset_b_level", int'(b_level), 0);
    check("reset_c_level", int'(c_level), 16);
    rst = 1;
    tick();

    // Directed table: pulse phase, then one pixel checked against hand-derived values.
    for (int i = 0; i < 10; i++) begin
      en_b = vecs[i].en;
      for (int k = 0; k < vecs[i].rep; k++) begin
        binc = vecs[i].binc; bdec = vecs[i].bdec;
        cinc = vecs[i].cinc; cdec = vecs[i].cdec;
        tick();
      end
      idle();
      send_pixel(vecs[i], $sformatf("vec%0d", i));
    end

    // Random run against the model; levels start where the table left them.
    mb = 0; mc = 48; pb = 0; pc = 48;
    for (int i = 0; i < 803; i++) begin
      if (i < 800) begin
        en_b     = ($urandom_range(0, 3) != 0);
        binc     = ($urandom_range(0, 3) == 0);
        bdec     = ($urandom_range(0, 3) == 0);
        cinc     = ($urandom_range(0, 3) == 0);
        cdec     = ($urandom_range(0, 3) == 0);
        in_valid = ($urandom_range(0, 4) != 0);
        in_vsync = in_valid && ($urandom_range(0, 19) == 0);
        in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
      end else begin
        idle();
      end
      ub = mb; uc = mc;
`ifdef BC_FRAME_SYNC_EN
      if (in_valid && in_vsync) begin ub = pb; uc = pc; end
`endif
      e.v  = in_valid;
      e.vs = in_vsync;
      e.r  = pix_model(int'(in_r), ub, uc, en_b);
      e.g  = pix_model(int'(in_g), ub, uc, en_b);
      e.b  = pix_model(int'(in_b), ub, uc, en_b);
      q.push_back(e);
      tick();
`ifdef BC_FRAME_SYNC_EN
      if (in_valid && in_vsync) begin mb = pb; mc = pc; end
      if (en_b) begin
        pb = sat(pb, binc, bdec, 16, -128, 128);
        pc = sat(pc, cinc, cdec, 2, 4, 48);
      end
`else
      if (en_b) begin
        mb = sat(mb, binc, bdec, 16, -128, 128);
        mc = sat(mc, cinc, cdec, 2, 4, 48);
      end
`endif
      check($sformatf("rnd%0d_b_level", i), int'(b_level), mb);
      check($sformatf("rnd%0d_c_level", i), int'(c_level), mc);
      if (q.size() == 3) begin
        e = q.pop_front();
        check($sformatf("rnd%0d_valid", i), int'(out_valid), int'(e.v));
        if (e.v) begin
          check($sformatf("rnd%0d_vsync", i), int'(out_vsync), int'(e.vs));
          check($sformatf("rnd%0d_r", i), int'(out_r), e.r);
          check($sformatf("rnd%0d_g", i), int'(out_g), e.g);
          check($sformatf("rnd%0d_b", i), int'(out_b), e.b);
        end
      end
    end
    idle();

    // Clean restart, then reset asserted while pixels are streaming out.
    rst = 0; tick(); rst = 1; tick();
    en_b = 1; binc = 1;
    tick(); tick();
    binc = 0;
    in_valid = 1; in_vsync = 1; in_r = 10; in_g = 20; in_b = 30;
    tick();
    in_vsync = 0;
    tick(); tick();
    check("midrst_pre_valid", int'(out_valid), 1);
    check("midrst_pre_b_level", int'(b_level), 32);
    #1 rst = 0;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_b_level", int'(b_level), 0);
    check("midrst_c_level", int'(c_level), 16);
    check("midrst_out_r", int'(out_r), 0);
    tick();
    idle();
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("postrst_idle%0d_valid", k), int'(out_valid), 0);
    end
    send_pixel(uv, "postrst");

    // A brightness pulse in the middle of a frame.
    en_b = 1; binc = 1;
    tick();
    binc = 0;
`ifdef BC_FRAME_SYNC_EN
    check("fsync_hold0_b_level", int'(b_level), 0);
    in_valid = 1; in_vsync = 0; in_r = 50; in_g = 50; in_b = 50;
    tick();
    check("fsync_hold1_b_level", int'(b_level), 0);
    in_vsync = 1;
    tick();
    check("fsync_load_b_level", int'(b_level), 16);
    idle();
`else
    check("nosync_b_level", int'(b_level), 16);
`endif
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
